// File: rtl/core_trap_sequencer.sv
// Trap entry / xRET sequencer: latches one event, then walks
// cause CSR writes, mstatus/privilege update and fetch redirect.
package core_trap_pkg;
    typedef enum logic [1:0] {
        PRV_U = 2'b00,
        PRV_S = 2'b01,
        PRV_M = 2'b11
    } prv_mode_t;
endpackage

module core_trap_sequencer
    import core_trap_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [31:0] req_cause,
    input  logic [31:0] req_epc,
    input  logic [31:0] req_tval,
    input  logic [31:0] csr_mstatus_ff,
    input  logic [31:0] csr_medeleg_ff,
    input  logic [31:0] csr_mideleg_ff,
    input  logic [31:0] csr_mtvec_ff,
    input  logic [31:0] csr_stvec_ff,
    input  logic [31:0] csr_mepc_ff,
    input  logic [31:0] csr_sepc_ff,
    input  prv_mode_t   prv_mode_ff,
    output logic [31:0] sepc_wd,
    output logic        sepc_we,
    output logic [31:0] scause_wd,
    output logic        scause_we,
    output logic [31:0] stval_wd,
    output logic        stval_we,
    output logic [31:0] mepc_wd,
    output logic        mepc_we,
    output logic [31:0] mcause_wd,
    output logic        mcause_we,
    output logic [31:0] mtval_wd,
    output logic        mtval_we,
    output logic [31:0] mstatus_wd,
    output logic        mstatus_we,
    output prv_mode_t   prv_mode_wd,
    output logic        prv_mode_we,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        CAUSE,
        STATUS,
        REDIRECT
    } state_t;

    localparam logic [1:0] K_TRAP = 2'b00;
    localparam logic [1:0] K_MRET = 2'b01;
    localparam logic [1:0] K_SRET = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  kind_q, kind_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tval_q, tval_d;
    prv_mode_t   prv_q, prv_d;
    logic        tgt_s_q, tgt_s_d;

    logic        accept;
    logic        deleg_bit;
    logic        is_xret;
    logic [31:0] ms_new;
    logic [31:0] tvec;
    logic [31:0] vec_off;

    always_comb begin
        accept    = req_valid && (state_q == IDLE);
        deleg_bit = req_cause[31] ? csr_mideleg_ff[req_cause[4:0]]
                                  : csr_medeleg_ff[req_cause[4:0]];
        is_xret   = (req_kind == K_MRET) || (req_kind == K_SRET);
        state_d   = state_q;
        kind_d    = kind_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        tval_d    = tval_q;
        prv_d     = prv_q;
        tgt_s_d   = tgt_s_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    kind_d  = is_xret ? req_kind : K_TRAP;
                    cause_d = req_cause;
                    epc_d   = req_epc;
                    tval_d  = req_tval;
                    prv_d   = prv_mode_ff;
                    tgt_s_d = (prv_mode_ff != PRV_M) && deleg_bit;
                    state_d = is_xret ? STATUS : CAUSE;
                end
            end
            CAUSE:    state_d = STATUS;
            STATUS:   state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            kind_q  <= K_TRAP;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
            prv_q   <= PRV_U;
            tgt_s_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
            prv_q   <= prv_d;
            tgt_s_q <= tgt_s_d;
        end
    end

    // CSR-derived data is taken from the inputs of the cycle it is written.
    always_comb begin
        req_ready      = (state_q == IDLE);
        busy           = (state_q != IDLE);
        sepc_wd        = '0;
        sepc_we        = 1'b0;
        scause_wd      = '0;
        scause_we      = 1'b0;
        stval_wd       = '0;
        stval_we       = 1'b0;
        mepc_wd        = '0;
        mepc_we        = 1'b0;
        mcause_wd      = '0;
        mcause_we      = 1'b0;
        mtval_wd       = '0;
        mtval_we       = 1'b0;
        mstatus_wd     = '0;
        mstatus_we     = 1'b0;
        prv_mode_wd    = PRV_U;
        prv_mode_we    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ms_new         = csr_mstatus_ff;
        tvec           = tgt_s_q ? csr_stvec_ff : csr_mtvec_ff;
        vec_off        = '0;
        case (state_q)
            CAUSE: begin
                if (tgt_s_q) begin
                    sepc_we   = 1'b1;
                    scause_we = 1'b1;
                    stval_we  = 1'b1;
                    sepc_wd   = epc_q;
                    scause_wd = cause_q;
                    stval_wd  = tval_q;
                end else begin
                    mepc_we   = 1'b1;
                    mcause_we = 1'b1;
                    mtval_we  = 1'b1;
                    mepc_wd   = epc_q;
                    mcause_wd = cause_q;
                    mtval_wd  = tval_q;
                end
            end
            STATUS: begin
                mstatus_we  = 1'b1;
                prv_mode_we = 1'b1;
                case (kind_q)
                    K_MRET: begin
                        prv_mode_wd   = prv_mode_t'(csr_mstatus_ff[12:11]);
                        ms_new[3]     = csr_mstatus_ff[7];
                        ms_new[7]     = 1'b1;
                        ms_new[12:11] = 2'b00;
                    end
                    K_SRET: begin
                        prv_mode_wd = csr_mstatus_ff[8] ? PRV_S : PRV_U;
                        ms_new[1]   = csr_mstatus_ff[5];
                        ms_new[5]   = 1'b1;
                        ms_new[8]   = 1'b0;
                    end
                    default: begin
                        if (tgt_s_q) begin
                            prv_mode_wd = PRV_S;
                            ms_new[5]   = csr_mstatus_ff[1];
                            ms_new[1]   = 1'b0;
                            ms_new[8]   = prv_q[0];
                        end else begin
                            prv_mode_wd   = PRV_M;
                            ms_new[7]     = csr_mstatus_ff[3];
                            ms_new[3]     = 1'b0;
                            ms_new[12:11] = prv_q;
                        end
                    end
                endcase
                mstatus_wd = ms_new;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                if (tvec[1:0] == 2'b01 && cause_q[31])
                    vec_off = {25'b0, cause_q[4:0], 2'b00};
                case (kind_q)
                    K_MRET:  redirect_pc = csr_mepc_ff;
                    K_SRET:  redirect_pc = csr_sepc_ff;
                    default: redirect_pc = {tvec[31:2], 2'b00} + vec_off;
                endcase
            end
            default: ;
        endcase
    end

endmodule
